// File: rtl/byte_serial_addsub_seq.sv
// byte_serial_addsub_seq: 32-bit (8*NUM_BYTES) add/subtract sequencer that
// time-shares one external 8-bit carry-lookahead slice, LSB byte first.
// Optional build macro ADDSEQ_FLAGS_EN adds registered out_zero/out_neg flags.
module byte_serial_addsub_seq #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sub,
    input  logic [8*NUM_BYTES-1:0]   in_a,
    input  logic [8*NUM_BYTES-1:0]   in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NUM_BYTES-1:0]   out_result,
    output logic                     out_cout,
    output logic                     out_ovf,
`ifdef ADDSEQ_FLAGS_EN
    output logic                     out_zero,
    output logic                     out_neg,
`endif
    output logic [7:0]               slice_a,
    output logic [7:0]               slice_b,
    output logic                     slice_cin,
    input  logic [7:0]               slice_sum,
    input  logic                     slice_gn,
    input  logic                     slice_pn,
    input  logic                     slice_c7
);

    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                   state_q;
    logic [1:0]                   state_d;
    logic [NUM_BYTES-1:0][7:0]    a_q;
    logic [NUM_BYTES-1:0][7:0]    b_q;
    logic [NUM_BYTES-1:0][7:0]    result_q;
    logic                         sub_q;
    logic                         carry_q;
    logic [IDX_W-1:0]             byte_idx;
    logic                         carry_next_c;
    logic                         last_byte_c;

    assign out_result   = result_q;
    assign carry_next_c = slice_gn | (slice_pn & carry_q);
    assign last_byte_c  = (byte_idx == LAST_IDX);

    // Next-state selection for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)    state_d = RUN;
            RUN:     if (last_byte_c) state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Slice drive: current operand byte while running, quiet zeros otherwise
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state_q == RUN) begin
            slice_a   = a_q[byte_idx];
            slice_b   = b_q[byte_idx] ^ {8{sub_q}};
            slice_cin = carry_q;
        end
    end

`ifdef ADDSEQ_FLAGS_EN
    logic [NUM_BYTES-1:0][7:0] result_next_c;

    // Full result as it will look after the final byte lands, for the flags
    always_comb begin
        result_next_c           = result_q;
        result_next_c[byte_idx] = slice_sum;
    end

    // Zero/negative flags captured on the final byte step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (state_q == RUN && last_byte_c) begin
            out_zero <= (result_next_c == '0);
            out_neg  <= result_next_c[NUM_BYTES-1][7];
        end
    end
`endif

    // Operand capture, byte stepping, carry chain and result/handshake registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            byte_idx  <= '0;
            result_q  <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        sub_q    <= in_sub;
                        carry_q  <= in_sub;
                        byte_idx <= '0;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    result_q[byte_idx] <= slice_sum;
                    carry_q            <= carry_next_c;
                    if (last_byte_c) begin
                        byte_idx  <= '0;
                        out_cout  <= carry_next_c;
                        out_ovf   <= carry_next_c ^ slice_c7;
                        out_valid <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_addsub_seq.sv
// Self-checking bench for byte_serial_addsub_seq with a behavioural 8-bit slice.
module tb_byte_serial_addsub_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sub;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_cout;
    logic          out_ovf;
`ifdef ADDSEQ_FLAGS_EN
    logic          out_zero;
    logic          out_neg;
`endif
    logic [7:0]    slice_a;
    logic [7:0]    slice_b;
    logic          slice_cin;
    logic [7:0]    slice_sum;
    logic          slice_gn;
    logic          slice_pn;
    logic          slice_c7;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    byte_serial_addsub_seq #(.NUM_BYTES(NB)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sub     (in_sub),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
`ifdef ADDSEQ_FLAGS_EN
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`endif
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_gn   (slice_gn),
        .slice_pn   (slice_pn),
        .slice_c7   (slice_c7)
    );

    // Behavioural 8-bit slice: sum, block generate, OR-based block propagate, carry into bit 7
    logic [8:0] full9;
    logic [8:0] gen9;
    logic [7:0] low8;
    assign full9     = {1'b0, slice_a} + {1'b0, slice_b} + 9'(slice_cin);
    assign gen9      = {1'b0, slice_a} + {1'b0, slice_b};
    assign low8      = {1'b0, slice_a[6:0]} + {1'b0, slice_b[6:0]} + 8'(slice_cin);
    assign slice_sum = full9[7:0];
    assign slice_gn  = gen9[8];
    assign slice_pn  = &(slice_a | slice_b);
    assign slice_c7  = low8[7];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        e.res  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
        e.zero = (e.res == '0);
        e.neg  = e.res[W-1];
        return e;
    endfunction

    // Drive one operand at the accept edge; expected result enters the scoreboard here
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit hold);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        sb.push_back(model(a, b, sub));
        @(posedge clock);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen on a falling edge, bounded
    task automatic wait_done(output int n, output bit timed_out);
        n         = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (slice_cin !== 1'b0) begin failures++; $display("FAIL reset_slice_cin got=%b exp=0", slice_cin); end
        checks++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", out_cout, out_ovf); end
    endtask

    task automatic test_ovf_add;
        int n; bit to; exp_t e;
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovf_in_ready_run got=%b exp=0", in_ready); end
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0 || n != 4) begin failures++; $display("FAIL ovf_latency got=%0d timeout=%b exp=4", n, to); end
        checks++; if (out_result !== e.res) begin failures++; $display("FAIL ovf_result got=%h exp=%h", out_result, e.res); end
        checks++; if (out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_ovf got=%b exp=1", out_ovf); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL ovf_cout got=%b exp=0", out_cout); end
        checks++; if (slice_a !== 8'h00 || slice_cin !== 1'b0) begin failures++; $display("FAIL done_slice_quiet got=%h/%b exp=00/0", slice_a, slice_cin); end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL ovf_release got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (out_result !== 32'h8000_0000) begin failures++; $display("FAIL ovf_result_hold got=%h exp=80000000", out_result); end
    endtask

    task automatic test_wrap_add;
        int n; bit to; exp_t e;
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL wrap_timeout got=%b exp=0", to); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL wrap_result got=%h exp=0", out_result); end
        checks++; if (out_cout !== e.cout || out_ovf !== e.ovf) begin failures++; $display("FAIL wrap_flags got=%b%b exp=%b%b", out_cout, out_ovf, e.cout, e.ovf); end
`ifdef ADDSEQ_FLAGS_EN
        checks++; if (out_zero !== 1'b1 || out_neg !== 1'b0) begin failures++; $display("FAIL wrap_zero_neg got=%b%b exp=10", out_zero, out_neg); end
`endif
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_sub_borrow;
        int n; bit to; exp_t e;
        accept(32'd5, 32'd7, 1'b1, 1'b0);
        checks++; if (slice_cin !== 1'b1) begin failures++; $display("FAIL sub_cin_byte0 got=%b exp=1", slice_cin); end
        checks++; if (slice_a !== 8'h05 || slice_b !== 8'hF8) begin failures++; $display("FAIL sub_slice_ops got=%h/%h exp=05/f8", slice_a, slice_b); end
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0 || n != 4) begin failures++; $display("FAIL sub_latency got=%0d timeout=%b exp=4", n, to); end
        checks++; if (out_result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffffffe", out_result); end
        checks++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin failures++; $display("FAIL sub_flags got=%b%b exp=00", out_cout, out_ovf); end
`ifdef ADDSEQ_FLAGS_EN
        checks++; if (out_neg !== 1'b1 || out_zero !== 1'b0) begin failures++; $display("FAIL sub_neg_zero got=%b%b exp=10", out_neg, out_zero); end
`endif
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n; bit to; exp_t e;
        accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        in_a   = 32'h0000_0100;
        in_b   = 32'h0000_0001;
        in_sub = 1'b1;
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", to); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.res) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b%b %h exp=10 %h", i, out_valid, in_ready, out_result, e.res);
            end
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b%b exp=10", in_ready, out_valid); end
        sb.push_back(model(in_a, in_b, in_sub));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0 || n != 4) begin failures++; $display("FAIL bp2_latency got=%0d timeout=%b exp=4", n, to); end
        checks++; if (out_result !== 32'h0000_00FF || out_cout !== e.cout) begin failures++; $display("FAIL bp2_result got=%h/%b exp=000000ff/%b", out_result, out_cout, e.cout); end
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp2_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        int n; bit to; exp_t e;
        accept(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        checks++; if (slice_a !== 8'hAD) begin failures++; $display("FAIL mid_byte2 got=%h exp=ad", slice_a); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_hs got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (slice_a !== 8'h00 || out_result !== 32'h0) begin failures++; $display("FAIL mid_reset_out got=%h/%h exp=00/0", slice_a, out_result); end
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        accept(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        wait_done(n, to);
        e = sb.pop_front();
        checks++; if (to !== 1'b0 || n != 4) begin failures++; $display("FAIL mid_latency got=%0d timeout=%b exp=4", n, to); end
        checks++; if (out_result !== 32'h7FFF_FFFF) begin failures++; $display("FAIL mid_result got=%h exp=7fffffff", out_result); end
        checks++; if (out_ovf !== 1'b1 || out_cout !== 1'b1) begin failures++; $display("FAIL mid_flags got=%b%b exp=11", out_ovf, out_cout); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_scoreboard got=%0d exp=0", sb.size()); end
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        int n; bit to; exp_t e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom();
            b = $urandom();
            s = 1'($urandom_range(1, 0));
            if (i == 0) begin a = '0; b = '0; s = 1'b1; end
            if (i == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; s = 1'b0; end
            accept(a, b, s, 1'b0);
            wait_done(n, to);
            e = sb.pop_front();
            checks++;
            if (to !== 1'b0 || n != 4 || out_result !== e.res || out_cout !== e.cout || out_ovf !== e.ovf) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h sub=%b got=%h c=%b v=%b n=%0d exp=%h c=%b v=%b", i, a, b, s, out_result, out_cout, out_ovf, n, e.res, e.cout, e.ovf);
            end
`ifdef ADDSEQ_FLAGS_EN
            checks++;
            if (out_zero !== e.zero || out_neg !== e.neg) begin
                failures++;
                $display("FAIL rand%0d_flags got=%b%b exp=%b%b", i, out_zero, out_neg, e.zero, e.neg);
            end
`endif
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ovf_add();
        test_wrap_add();
        test_sub_borrow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
